micro_sequencer: RTL and testbench

Control-section sequencer for the microprogrammed datapath. It owns the micro-program counter and drives the 11-bit address into the microinstruction ROM. It takes back the 41-bit microword, splits it into datapath control fields, and computes the next microaddress from the COND/JUMP ADDR fields, the PSR flags and the IR. It stalls on memory reads and writes with a ready handshake and a bounded timeout.

---
 rtl/uSEQ_pkg.sv | 40 ++++
 rtl/micro_sequencer_if.sv | 30 +++
 rtl/useq_next_addr.sv | 21 ++
 rtl/micro_sequencer.sv | 91 +++++++++
 tb/tb_micro_sequencer.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/uSEQ_pkg.sv
// uSEQ_pkg: shared widths, microword field map, COND encodings and FSM states for the micro-sequencer
package uSEQ_pkg;
  localparam int DATA_BUS_ADDR = 11;
  localparam int DATA_BUS_WORD = 41;
  localparam int CNT_W = 8;
  localparam int F_A_HI = 40;
  localparam int F_A_LO = 35;
  localparam int F_AMUX = 34;
  localparam int F_B_HI = 33;
  localparam int F_B_LO = 28;
  localparam int F_BMUX = 27;
  localparam int F_C_HI = 26;
  localparam int F_C_LO = 21;
  localparam int F_CMUX = 20;
  localparam int F_RD = 19;
  localparam int F_WR = 18;
  localparam int F_ALU_HI = 17;
  localparam int F_ALU_LO = 14;
  localparam int F_COND_HI = 13;
  localparam int F_COND_LO = 11;
  localparam int F_JADDR_HI = 10;
  localparam int F_JADDR_LO = 0;
  localparam logic DEC_LEAD = 1'b1;
  localparam logic [1:0] DEC_TAIL = 2'b00;
  typedef enum logic [2:0] {
    COND_NONE = 3'b000,
    COND_N = 3'b001,
    COND_Z = 3'b010,
    COND_V = 3'b011,
    COND_C = 3'b100,
    COND_IR13 = 3'b101,
    COND_JUMP = 3'b110,
    COND_DECODE = 3'b111
  } cond_e;
  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    RUN = 2'd1,
    WAIT_MEM = 2'd2
  } state_e;
endpackage

// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: ROM bus, datapath control fields and memory handshake of the sequencer
interface micro_sequencer_if;
  import uSEQ_pkg::*;
  logic [DATA_BUS_ADDR-1:0] uSEQ_uADDR_Out;
  logic [DATA_BUS_WORD-1:0] uSEQ_uWORD_In;
  logic [31:0] uSEQ_IR_In;
  logic [3:0] uSEQ_PSR_In;
  logic uSEQ_MEM_READY_In;
  logic [5:0] uSEQ_A_Out;
  logic [5:0] uSEQ_B_Out;
  logic [5:0] uSEQ_C_Out;
  logic uSEQ_AMUX_Out;
  logic uSEQ_BMUX_Out;
  logic uSEQ_CMUX_Out;
  logic uSEQ_RD_Out;
  logic uSEQ_WR_Out;
  logic [3:0] uSEQ_ALU_Out;
  logic uSEQ_COMMIT_Out;
  logic uSEQ_BUSERR_Out;
  modport master (
    input uSEQ_uWORD_In, uSEQ_IR_In, uSEQ_PSR_In, uSEQ_MEM_READY_In,
    output uSEQ_uADDR_Out, uSEQ_A_Out, uSEQ_B_Out, uSEQ_C_Out, uSEQ_AMUX_Out, uSEQ_BMUX_Out,
    uSEQ_CMUX_Out, uSEQ_RD_Out, uSEQ_WR_Out, uSEQ_ALU_Out, uSEQ_COMMIT_Out, uSEQ_BUSERR_Out
  );
  modport slave (
    output uSEQ_uWORD_In, uSEQ_IR_In, uSEQ_PSR_In, uSEQ_MEM_READY_In,
    input uSEQ_uADDR_Out, uSEQ_A_Out, uSEQ_B_Out, uSEQ_C_Out, uSEQ_AMUX_Out, uSEQ_BMUX_Out,
    uSEQ_CMUX_Out, uSEQ_RD_Out, uSEQ_WR_Out, uSEQ_ALU_Out, uSEQ_COMMIT_Out, uSEQ_BUSERR_Out
  );
endinterface

// File: rtl/useq_next_addr.sv
// useq_next_addr: combinational next-microaddress select from COND, PSR flags, IR and JADDR
module useq_next_addr
  import uSEQ_pkg::*;
(
  input  cond_e                    i_cond,
  input  logic [3:0]               i_flags,
  input  logic                     i_ir13,
  input  logic [7:0]               i_op,
  input  logic [DATA_BUS_ADDR-1:0] i_jaddr,
  input  logic [DATA_BUS_ADDR-1:0] i_upc,
  output logic [DATA_BUS_ADDR-1:0] o_addr
);
  logic [DATA_BUS_ADDR-1:0] w_inc;
  logic w_take;
  assign w_inc = i_upc + 11'd1;
  assign w_take = (i_cond == COND_N && i_flags[3]) || (i_cond == COND_Z && i_flags[2]) ||
                  (i_cond == COND_V && i_flags[1]) || (i_cond == COND_C && i_flags[0]) ||
                  (i_cond == COND_IR13 && i_ir13) || i_cond == COND_JUMP;
  // i_op is {IR[31:30], IR[24:19]}: op and op3 pick a 4-slot block in the upper ROM half
  assign o_addr = i_cond == COND_DECODE ? {DEC_LEAD, i_op, DEC_TAIL} : w_take ? i_jaddr : w_inc;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC, run/stall FSM with memory timeout trap, and microword field decode
module micro_sequencer
  import uSEQ_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter logic [DATA_BUS_ADDR-1:0] TRAP_ADDR = 11'd2046
) (
  input logic CLOCK_50,
  input logic RESET_InLow,
  micro_sequencer_if.master bus
);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(MEM_TIMEOUT - 1);
  state_e r_state, w_state_nxt;
  logic [DATA_BUS_ADDR-1:0] r_upc, w_upc_nxt, w_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_buserr, w_buserr_nxt, w_commit, w_mem, w_rdy;
  logic [DATA_BUS_WORD-1:0] w_word;
  cond_e w_cond;
  assign w_word = bus.uSEQ_uWORD_In;
  assign w_cond = cond_e'(w_word[F_COND_HI:F_COND_LO]);
  assign w_mem = w_word[F_RD] | w_word[F_WR];
  assign w_rdy = bus.uSEQ_MEM_READY_In;
  useq_next_addr u_next (
    .i_cond (w_cond),
    .i_flags(bus.uSEQ_PSR_In),
    .i_ir13 (bus.uSEQ_IR_In[13]),
    .i_op   ({bus.uSEQ_IR_In[31:30], bus.uSEQ_IR_In[24:19]}),
    .i_jaddr(w_word[F_JADDR_HI:F_JADDR_LO]),
    .i_upc  (r_upc),
    .o_addr (w_next)
  );
  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      r_state <= RESET_S;
      r_upc <= '0;
      r_cnt <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_upc <= w_upc_nxt;
      r_cnt <= w_cnt_nxt;
      r_buserr <= w_buserr_nxt;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_upc_nxt = r_upc;
    w_cnt_nxt = r_cnt;
    w_buserr_nxt = r_buserr;
    w_commit = 1'b0;
    case (r_state)
      RESET_S: w_state_nxt = RUN;
      RUN: begin
        if (!w_mem || w_rdy) begin
          w_commit = 1'b1;
          w_upc_nxt = w_next;
        end else begin
          w_cnt_nxt = '0;
          w_state_nxt = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (w_rdy) begin
          w_commit = 1'b1;
          w_upc_nxt = w_next;
          w_state_nxt = RUN;
        end else if (r_cnt == L_LAST) begin
          w_upc_nxt = TRAP_ADDR;
          w_buserr_nxt = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = RESET_S;
    endcase
  end
  assign bus.uSEQ_uADDR_Out = r_upc;
  assign bus.uSEQ_COMMIT_Out = w_commit;
  assign bus.uSEQ_BUSERR_Out = r_buserr;
  assign bus.uSEQ_A_Out = w_word[F_A_HI:F_A_LO];
  assign bus.uSEQ_B_Out = w_word[F_B_HI:F_B_LO];
  assign bus.uSEQ_C_Out = w_word[F_C_HI:F_C_LO];
  assign bus.uSEQ_AMUX_Out = w_word[F_AMUX];
  assign bus.uSEQ_BMUX_Out = w_word[F_BMUX];
  assign bus.uSEQ_CMUX_Out = w_word[F_CMUX];
  assign bus.uSEQ_ALU_Out = w_word[F_ALU_HI:F_ALU_LO];
  // strobes are gated by state so an asynchronous reset drops them at once
  assign bus.uSEQ_RD_Out = r_state != RESET_S && w_word[F_RD];
  assign bus.uSEQ_WR_Out = r_state != RESET_S && w_word[F_WR];
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed test-plan steps plus randomized ROM/flags/ready against a cycle model
module tb_micro_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  micro_sequencer_if bus ();
  micro_sequencer #(.MEM_TIMEOUT(15), .TRAP_ADDR(11'd2046)) dut (
    .CLOCK_50(clk),
    .RESET_InLow(rst_n),
    .bus(bus)
  );
  logic [40:0] rom [2048];
  assign bus.uSEQ_uWORD_In = rom[bus.uSEQ_uADDR_Out];
  int passed = 0;
  int total = 0;
  logic [10:0] m_pc;
  bit m_rst, m_waiting, m_buserr;
  int m_wait;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  function automatic logic [40:0] mkw(input logic [2:0] c, input logic [10:0] j, input logic rd, input logic wr);
    logic [40:0] w;
    w = {9'($urandom), 32'($urandom)};
    w[19] = rd;
    w[18] = wr;
    w[13:11] = c;
    w[10:0] = j;
    return w;
  endfunction
  function automatic logic [10:0] nxt(input logic [40:0] w, input logic [10:0] pc, input logic [3:0] f, input logic [31:0] ir);
    logic [10:0] inc, j;
    inc = 11'((int'(pc) + 1) % 2048);
    j = w[10:0];
    case (w[13:11])
      3'd0: return inc;
      3'd1: return f[3] ? j : inc;
      3'd2: return f[2] ? j : inc;
      3'd3: return f[1] ? j : inc;
      3'd4: return f[0] ? j : inc;
      3'd5: return ir[13] ? j : inc;
      3'd6: return j;
      default: return 11'(1024 + int'(ir[31:30]) * 256 + int'(ir[24:19]) * 4);
    endcase
  endfunction
  task automatic cyc(input logic [31:0] ir, input logic [3:0] psr, input logic rdy);
    logic [40:0] w;
    logic mem;
    @(negedge clk);
    bus.uSEQ_IR_In = ir;
    bus.uSEQ_PSR_In = psr;
    bus.uSEQ_MEM_READY_In = rdy;
    #1;
    w = rom[m_pc];
    mem = w[19] | w[18];
    chk("uaddr", 64'(bus.uSEQ_uADDR_Out), 64'(m_pc));
    chk("commit", 64'(bus.uSEQ_COMMIT_Out), 64'(!m_rst && (!mem || rdy)));
    chk("rdwr", 64'({bus.uSEQ_RD_Out, bus.uSEQ_WR_Out}), 64'(m_rst ? 2'b00 : w[19:18]));
    chk("buserr", 64'(bus.uSEQ_BUSERR_Out), 64'(m_buserr));
    chk("fields", 64'({bus.uSEQ_A_Out, bus.uSEQ_AMUX_Out, bus.uSEQ_B_Out, bus.uSEQ_BMUX_Out,
        bus.uSEQ_C_Out, bus.uSEQ_CMUX_Out, bus.uSEQ_ALU_Out}), 64'({w[40:20], w[17:14]}));
    if (m_rst) m_rst = 0;
    else if (!mem || rdy) begin
      m_pc = nxt(w, m_pc, psr, ir);
      m_waiting = 0;
    end else if (!m_waiting) begin
      m_waiting = 1;
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == 15) begin
        m_pc = 11'd2046;
        m_buserr = 1;
        m_waiting = 0;
      end
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_uaddr", 64'(bus.uSEQ_uADDR_Out), 64'd0);
    chk("rst_rdwr", 64'({bus.uSEQ_RD_Out, bus.uSEQ_WR_Out}), 64'd0);
    chk("rst_buserr", 64'(bus.uSEQ_BUSERR_Out), 64'd0);
    chk("rst_commit", 64'(bus.uSEQ_COMMIT_Out), 64'd0);
    m_pc = 11'd0;
    m_rst = 1;
    m_waiting = 0;
    m_buserr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    logic [31:0] ir;
    rst_n = 1'b0;
    bus.uSEQ_IR_In = '0;
    bus.uSEQ_PSR_In = '0;
    bus.uSEQ_MEM_READY_In = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = mkw(3'd0, 11'd0, 1'b0, 1'b0);
    rom[2] = mkw(3'd7, 11'd0, 1'b0, 1'b0);
    rom[1600] = mkw(3'd6, 11'd2, 1'b0, 1'b0);
    rom[1624] = mkw(3'd6, 11'd8, 1'b0, 1'b0);
    rom[8] = mkw(3'd2, 11'd12, 1'b0, 1'b0);
    rom[12] = mkw(3'd6, 11'd8, 1'b0, 1'b0);
    rom[9] = mkw(3'd0, 11'd0, 1'b1, 1'b0);
    rom[10] = mkw(3'd0, 11'd0, 1'b0, 1'b1);
    rom[2046] = mkw(3'd6, 11'd2047, 1'b0, 1'b0);
    do_reset();
    cyc('0, '0, 1'b0);
    chk("rel_commit0", 64'(bus.uSEQ_COMMIT_Out), 64'd0);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    chk("rel_addr1", 64'(bus.uSEQ_uADDR_Out), 64'd1);
    ir = $urandom;
    ir[31:30] = 2'b10;
    ir[24:19] = 6'b010000;
    cyc(ir, '0, 1'b0);
    chk("rel_addr2", 64'(bus.uSEQ_uADDR_Out), 64'd2);
    cyc('0, '0, 1'b0);
    chk("dec_addcc", 64'(bus.uSEQ_uADDR_Out), 64'd1600);
    ir[24:19] = 6'b010110;
    cyc(ir, '0, 1'b0);
    cyc('0, '0, 1'b0);
    chk("dec_1624", 64'(bus.uSEQ_uADDR_Out), 64'd1624);
    cyc('0, 4'b0100, 1'b0);
    cyc('0, '0, 1'b0);
    chk("br_taken", 64'(bus.uSEQ_uADDR_Out), 64'd12);
    cyc('0, 4'b1011, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc('0, '0, k == 3);
      chk("stall_hold", 64'(bus.uSEQ_uADDR_Out), 64'd9);
      chk("stall_commit", 64'(bus.uSEQ_COMMIT_Out), 64'(k == 3));
    end
    for (int k = 0; k < 16; k++) begin
      cyc('0, '0, 1'b0);
      chk("to_hold", 64'(bus.uSEQ_uADDR_Out), 64'd10);
      chk("to_nocommit", 64'(bus.uSEQ_COMMIT_Out), 64'd0);
    end
    cyc('0, '0, 1'b0);
    chk("to_trap", 64'(bus.uSEQ_uADDR_Out), 64'd2046);
    chk("to_buserr", 64'(bus.uSEQ_BUSERR_Out), 64'd1);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    chk("wrap", 64'(bus.uSEQ_uADDR_Out), 64'd0);
    chk("buserr_sticky", 64'(bus.uSEQ_BUSERR_Out), 64'd1);
    rom[1] = mkw(3'd0, 11'd0, 1'b1, 1'b0);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    cyc('0, '0, 1'b0);
    chk("wait_rd", 64'(bus.uSEQ_RD_Out), 64'd1);
    do_reset();
    for (int i = 0; i < 2048; i++) rom[i] = {9'($urandom), 32'($urandom)};
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      cyc($urandom, 4'($urandom), $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
